// File: rtl/commit_if.sv
// Commit-unit handshake bundle: ROB head in, commit/store port out.
interface commit_if;
  logic       rob_head_ready;
  logic [2:0] rob_head_opcode;
  logic [2:0] rob_head_dest;
  logic [2:0] rob_head_value;
  logic       commit_en;
  logic       st_valid;
  logic [2:0] st_addr;
  logic [2:0] st_data;
  logic       st_ready;

  // ROB / memory side
  modport master (
    output rob_head_ready, rob_head_opcode, rob_head_dest, rob_head_value, st_ready,
    input  commit_en, st_valid, st_addr, st_data
  );

  // commit unit side
  modport slave (
    input  rob_head_ready, rob_head_opcode, rob_head_dest, rob_head_value, st_ready,
    output commit_en, st_valid, st_addr, st_data
  );
endinterface

// File: rtl/commit_unit.sv
// In-order commit stage: retires the ROB head, owns the architectural
// register file, drives a single store port and a one-cycle commit trace.
module commit_unit (
  input  logic        clk,
  input  logic        rst_n,
  commit_if.slave     cif,
  input  logic [2:0]  rd_addr_a,
  input  logic [2:0]  rd_addr_b,
  output logic [2:0]  rd_data_a,
  output logic [2:0]  rd_data_b,
  output logic        halted,
  output logic [7:0]  retired,
  output logic        trace_valid,
  output logic [2:0]  trace_opcode,
  output logic [2:0]  trace_dest,
  output logic [2:0]  trace_value
);

  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_HALT  = 3'b111;

  typedef enum logic [1:0] {RUN, ST_WAIT, HALTED} state_t;

  state_t          r_state, w_next;
  logic [7:0][2:0] r_rf;
  logic [2:0]      r_st_addr, r_st_data;
  logic [7:0]      r_retired;
  logic            r_tr_vld;
  logic [2:0]      r_tr_op, r_tr_dest, r_tr_val;

  logic       w_commit, w_st_latch, w_rf_we;
  logic [2:0] w_tr_op, w_tr_dest, w_tr_val;

  // Next-state and commit decode; ST_WAIT looks only at st_ready and the latched store.
  always_comb begin
    w_next     = r_state;
    w_commit   = 1'b0;
    w_st_latch = 1'b0;
    case (r_state)
      RUN: begin
        if (cif.rob_head_ready) begin
          if (cif.rob_head_opcode == OP_STORE) begin
            w_st_latch = 1'b1;
            w_next     = ST_WAIT;
          end else begin
            w_commit = 1'b1;
            if (cif.rob_head_opcode == OP_HALT) w_next = HALTED;
          end
        end
      end
      ST_WAIT: begin
        if (cif.st_ready) begin
          w_commit = 1'b1;
          w_next   = RUN;
        end
      end
      HALTED:  w_next = HALTED;
      default: w_next = RUN;
    endcase
  end

  // Only RUN commits can write registers (stores commit from ST_WAIT); r0 is never written.
  assign w_rf_we = w_commit && (r_state == RUN) &&
                   (cif.rob_head_opcode != OP_NOP) && (cif.rob_head_opcode != OP_HALT) &&
                   (cif.rob_head_dest != 3'd0);

  // A store commit is traced from the latched copy, not the live head.
  assign w_tr_op   = (r_state == ST_WAIT) ? OP_STORE  : cif.rob_head_opcode;
  assign w_tr_dest = (r_state == ST_WAIT) ? r_st_addr : cif.rob_head_dest;
  assign w_tr_val  = (r_state == ST_WAIT) ? r_st_data : cif.rob_head_value;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= RUN;
    else        r_state <= w_next;
  end

  // Register file, store latch, retire counter and trace record.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rf      <= '0;
      r_st_addr <= '0;
      r_st_data <= '0;
      r_retired <= '0;
      r_tr_vld  <= 1'b0;
      r_tr_op   <= '0;
      r_tr_dest <= '0;
      r_tr_val  <= '0;
    end else begin
      if (w_rf_we) r_rf[cif.rob_head_dest] <= cif.rob_head_value;
      if (w_st_latch) begin
        r_st_addr <= cif.rob_head_dest;
        r_st_data <= cif.rob_head_value;
      end
      if (w_commit) begin
        r_retired <= r_retired + 8'd1;
        r_tr_op   <= w_tr_op;
        r_tr_dest <= w_tr_dest;
        r_tr_val  <= w_tr_val;
      end
      r_tr_vld <= w_commit;
    end
  end

  assign cif.commit_en = w_commit;
  assign cif.st_valid  = (r_state == ST_WAIT);
  assign cif.st_addr   = r_st_addr;
  assign cif.st_data   = r_st_data;

  // Reads see pre-write contents; r0 is hardwired to zero.
  assign rd_data_a = (rd_addr_a == 3'd0) ? 3'd0 : r_rf[rd_addr_a];
  assign rd_data_b = (rd_addr_b == 3'd0) ? 3'd0 : r_rf[rd_addr_b];

  assign halted       = (r_state == HALTED);
  assign retired      = r_retired;
  assign trace_valid  = r_tr_vld;
  assign trace_opcode = r_tr_op;
  assign trace_dest   = r_tr_dest;
  assign trace_value  = r_tr_val;

endmodule

// File: tb/tb_commit_unit.sv
// Self-checking bench for commit_unit: vector table for single-cycle commits,
// hand sequences for store stall, counter wrap, reset mid-store and halt.
module tb_commit_unit;

  typedef struct {
    logic [2:0] op;
    logic [2:0] dest;
    logic [2:0] val;
  } trace_t;

  typedef struct {
    logic       rdy;
    logic [2:0] op;
    logic [2:0] dest;
    logic [2:0] val;
    logic       exp_c;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] rd_addr_a = '0, rd_addr_b = '0;
  logic [2:0] rd_data_a, rd_data_b;
  logic       halted, trace_valid;
  logic [7:0] retired;
  logic [2:0] trace_opcode, trace_dest, trace_value;

  commit_if cif ();

  commit_unit u_dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cif          (cif),
    .rd_addr_a    (rd_addr_a),
    .rd_addr_b    (rd_addr_b),
    .rd_data_a    (rd_data_a),
    .rd_data_b    (rd_data_b),
    .halted       (halted),
    .retired      (retired),
    .trace_valid  (trace_valid),
    .trace_opcode (trace_opcode),
    .trace_dest   (trace_dest),
    .trace_value  (trace_value)
  );

  always #5 clk = ~clk;

  int         total = 0;
  int         bad   = 0;
  logic [7:0] m_ret = '0;
  logic [2:0] m_rf [8];
  trace_t     sb [$];
  vec_t       vt [8];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic drive(input logic rdy, input logic [2:0] op, input logic [2:0] dest,
                       input logic [2:0] val, input logic sr);
    cif.rob_head_ready  = rdy;
    cif.rob_head_opcode = op;
    cif.rob_head_dest   = dest;
    cif.rob_head_value  = val;
    cif.st_ready        = sr;
  endtask

  function automatic trace_t mk(input logic [2:0] op, input logic [2:0] d, input logic [2:0] v);
    trace_t t;
    t.op = op; t.dest = d; t.val = v;
    return t;
  endfunction

  // One clock: check commit_en now, then trace/retired/reads after the edge.
  task automatic cycle(input string nm, input logic exp_c, input trace_t tr);
    trace_t got;
    #1;
    chk({nm, " commit_en"}, int'(cif.commit_en), int'(exp_c));
    if (exp_c) sb.push_back(tr);
    @(posedge clk);
    #1;
    if (exp_c) begin
      m_ret++;
      if (tr.op != 3'b000 && tr.op != 3'b101 && tr.op != 3'b111 && tr.dest != 3'd0)
        m_rf[tr.dest] = tr.val;
    end
    chk({nm, " trace_valid"}, int'(trace_valid), int'(exp_c));
    if (exp_c && sb.size() > 0) begin
      got = sb.pop_front();
      chk({nm, " trace_op"},   int'(trace_opcode), int'(got.op));
      chk({nm, " trace_dest"}, int'(trace_dest),   int'(got.dest));
      chk({nm, " trace_val"},  int'(trace_value),  int'(got.val));
    end
    chk({nm, " retired"}, int'(retired), int'(m_ret));
    rd_addr_a = tr.dest;
    rd_addr_b = 3'($urandom_range(0, 7));
    #1;
    chk({nm, " rd_a"}, int'(rd_data_a), int'(m_rf[rd_addr_a]));
    chk({nm, " rd_b"}, int'(rd_data_b), int'(m_rf[rd_addr_b]));
    @(negedge clk);
  endtask

  initial begin
    trace_t t;
    logic [7:0] ret0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;

    vt[0] = '{1'b1, 3'b001, 3'd3, 3'd5, 1'b1};   // ALU commit
    vt[1] = '{1'b0, 3'b001, 3'd4, 3'd6, 1'b0};   // head not ready
    vt[2] = '{1'b1, 3'b000, 3'd5, 3'd7, 1'b1};   // NOP commits, no write
    vt[3] = '{1'b1, 3'b010, 3'd0, 3'd7, 1'b1};   // write to r0 discarded
    vt[4] = '{1'b1, 3'b011, 3'd6, 3'd2, 1'b1};
    vt[5] = '{1'b1, 3'b100, 3'd7, 3'd1, 1'b1};
    vt[6] = '{1'b1, 3'b110, 3'd1, 3'd3, 1'b1};
    vt[7] = '{1'b1, 3'b001, 3'd3, 3'd4, 1'b1};   // overwrite r3

    drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b0);
    #2;
    chk("reset retired",     int'(retired),      0);
    chk("reset halted",      int'(halted),       0);
    chk("reset trace_valid", int'(trace_valid),  0);
    chk("reset st_valid",    int'(cif.st_valid), 0);
    chk("reset st_addr",     int'(cif.st_addr),  0);
    chk("reset st_data",     int'(cif.st_data),  0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single-cycle commits in RUN.
    for (int i = 0; i < 8; i++) begin
      drive(vt[i].rdy, vt[i].op, vt[i].dest, vt[i].val, 1'b0);
      cycle($sformatf("vec%0d", i), vt[i].exp_c, mk(vt[i].op, vt[i].dest, vt[i].val));
    end

    // Store stall: 3 cycles not ready, then handshake; head inputs scrambled meanwhile.
    drive(1'b1, 3'b101, 3'd2, 3'd6, 1'b0);
    #1 chk("st run st_valid", int'(cif.st_valid), 0);
    cycle("st latch", 1'b0, mk(3'b101, 3'd2, 3'd6));
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b001, 3'd5, 3'(i), (i == 3));
      #1;
      chk($sformatf("st%0d st_valid", i), int'(cif.st_valid), 1);
      chk($sformatf("st%0d st_addr", i),  int'(cif.st_addr),  2);
      chk($sformatf("st%0d st_data", i),  int'(cif.st_data),  6);
      cycle($sformatf("st%0d", i), (i == 3), mk(3'b101, 3'd2, 3'd6));
    end
    chk("st after st_valid", int'(cif.st_valid), 0);
    rd_addr_a = 3'd5;
    #1 chk("st rf r5 untouched", int'(rd_data_a), int'(m_rf[5]));

    // 256 back-to-back commits wrap the counter to its start value.
    ret0 = m_ret;
    for (int i = 0; i < 256; i++) begin
      drive(1'b1, 3'b001, 3'(i), 3'(i >> 3), 1'b0);
      cycle("wrap", 1'b1, mk(3'b001, 3'(i), 3'(i >> 3)));
    end
    chk("wrap retired", int'(retired), int'(ret0));

    // Reset while a store is waiting: abandoned immediately, nothing commits.
    drive(1'b1, 3'b101, 3'd4, 3'd3, 1'b0);
    cycle("rst latch", 1'b0, mk(3'b101, 3'd4, 3'd3));
    drive(1'b0, 3'b000, 3'd0, 3'd0, 1'b1);
    #1 chk("rst pre st_valid", int'(cif.st_valid), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst st_valid",  int'(cif.st_valid),  0);
    chk("rst commit_en", int'(cif.commit_en), 0);
    chk("rst retired",   int'(retired),       0);
    chk("rst st_addr",   int'(cif.st_addr),   0);
    m_ret = '0;
    for (int i = 0; i < 8; i++) m_rf[i] = '0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, 3'b001, 3'd6, 3'd5, 1'b1);
    cycle("post rst", 1'b1, mk(3'b001, 3'd6, 3'd5));

    // Halt: one commit, then nothing retires.
    chk("pre halt halted", int'(halted), 0);
    drive(1'b1, 3'b111, 3'd1, 3'd2, 1'b0);
    cycle("halt", 1'b1, mk(3'b111, 3'd1, 3'd2));
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'b001, 3'd2, 3'd7, 1'b1);
      chk($sformatf("halted%0d", i), int'(halted), 1);
      chk($sformatf("halted%0d st_valid", i), int'(cif.st_valid), 0);
      cycle($sformatf("halted%0d", i), 1'b0, mk(3'b001, 3'd2, 3'd7));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
